// File: rtl/fbfa_pkg.sv
// Shared constants, result type and a reference-sum helper for the registered ripple adder.
package fbfa_pkg;

    localparam int FBFA_DEFAULT_WIDTH = 4;
    localparam int FBFA_MAX_WIDTH     = 32;

    typedef struct packed {
        logic        cout;
        logic [31:0] sum;
    } fbfa_result_t;

    // Arithmetic (non-ripple) golden sum of the low 'width' bits, used by the bench.
    function automatic fbfa_result_t fbfa_ref_sum(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic        cin,
        input int unsigned width
    );
        fbfa_result_t res;
        logic [31:0]  mask;
        logic [32:0]  full;
        mask     = (width >= 32'd32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        full     = {1'b0, a & mask} + {1'b0, b & mask} + {32'd0, cin};
        res.sum  = full[31:0] & mask;
        res.cout = full[width];
        return res;
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One stage of the ripple chain: single-bit full adder.
module full_adder_bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);

    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));

endmodule

// File: rtl/four_bit_full_adder.sv
// Registered WIDTH-bit ripple-carry adder with carry-out, signed overflow and valid.
// Optional subtract mode (a - b via a + ~b + 1) enabled by defining FBFA_SUB_EN.
module four_bit_full_adder
    import fbfa_pkg::*;
#(
    parameter int WIDTH = FBFA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef FBFA_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid
);

    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_s;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_out_valid;

`ifdef FBFA_SUB_EN
    // Subtract inverts b and forces the carry-in high, ignoring cin.
    assign w_b_eff   = sub ? ~b : b;
    assign w_cin_eff = sub ? 1'b1 : cin;
`else
    assign w_b_eff   = b;
    assign w_cin_eff = cin;
`endif

    assign w_c[0] = w_cin_eff;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_stage
            full_adder_bit u_fa (
                .i_a  (a[gi]),
                .i_b  (w_b_eff[gi]),
                .i_ci (w_c[gi]),
                .o_s  (w_s[gi]),
                .o_co (w_c[gi+1])
            );
        end
    endgenerate

    // Result registers load only on valid; the valid flag itself tracks in_valid every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_sum  <= w_s;
                r_cout <= w_c[WIDTH];
                r_ovf  <= w_c[WIDTH] ^ w_c[WIDTH-1];
            end else begin
                r_sum  <= r_sum;
                r_cout <= r_cout;
                r_ovf  <= r_ovf;
            end
        end
    end

    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_four_bit_full_adder.sv
// Directed self-checking bench for four_bit_full_adder (WIDTH=4).
module tb_four_bit_full_adder;
    import fbfa_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
`ifdef FBFA_SUB_EN
    logic       sub;
`endif
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
    logic       out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    four_bit_full_adder #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef FBFA_SUB_EN
        .sub       (sub),
`endif
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] e_sum, input logic e_cout,
                           input logic e_ovf, input logic e_vld);
        chk({tag, ".sum"},       {28'd0, sum},        {28'd0, e_sum});
        chk({tag, ".cout"},      {31'd0, cout},       {31'd0, e_cout});
        chk({tag, ".ovf"},       {31'd0, ovf},        {31'd0, e_ovf});
        chk({tag, ".out_valid"}, {31'd0, out_valid},  {31'd0, e_vld});
    endtask

    task automatic drive(input logic [3:0] ta, input logic [3:0] tb_, input logic tc, input logic tv);
        a        = ta;
        b        = tb_;
        cin      = tc;
        in_valid = tv;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        fbfa_result_t ref_r;
        rst_n = 1'b0;
`ifdef FBFA_SUB_EN
        sub = 1'b0;
`endif
        drive(4'b0110, 4'b0100, 1'b0, 1'b1);
        tick();
        tick();
        chk_out("reset_hold", 4'b0000, 1'b0, 1'b0, 1'b0);

        rst_n = 1'b1;
        drive(4'b0110, 4'b0100, 1'b0, 1'b0);
        tick();
        chk_out("post_reset_idle", 4'b0000, 1'b0, 1'b0, 1'b0);

        drive(4'b0110, 4'b0100, 1'b0, 1'b1);
        tick();
        chk_out("v_0110_0100", 4'b1010, 1'b0, 1'b1, 1'b1);

        drive(4'b1000, 4'b1001, 1'b0, 1'b1);
        tick();
        chk_out("v_1000_1001", 4'b0001, 1'b1, 1'b1, 1'b1);

        drive(4'b1110, 4'b0010, 1'b0, 1'b1);
        tick();
        chk_out("v_1110_0010", 4'b0000, 1'b1, 1'b0, 1'b1);

        drive(4'b1010, 4'b1011, 1'b0, 1'b1);
        tick();
        chk_out("v_1010_1011", 4'b0101, 1'b1, 1'b1, 1'b1);

        drive(4'b1111, 4'b1111, 1'b1, 1'b1);
        tick();
        chk_out("v_all_ones_cin", 4'b1111, 1'b1, 1'b0, 1'b1);

        drive(4'b0001, 4'b0001, 1'b0, 1'b0);
        tick();
        chk_out("hold_invalid", 4'b1111, 1'b1, 1'b0, 1'b0);
        tick();
        chk_out("hold_invalid2", 4'b1111, 1'b1, 1'b0, 1'b0);

        drive(4'b0000, 4'b0000, 1'b0, 1'b1);
        tick();
        chk_out("v_zero", 4'b0000, 1'b0, 1'b0, 1'b1);

        drive(4'b0111, 4'b0000, 1'b1, 1'b1);
        tick();
        chk_out("v_0111_cin", 4'b1000, 1'b0, 1'b1, 1'b1);

        drive(4'b0011, 4'b0101, 1'b1, 1'b1);
        tick();
        ref_r = fbfa_ref_sum(32'h3, 32'h5, 1'b1, 32'd4);
        chk("ref_fn.sum",  {28'd0, sum},  ref_r.sum);
        chk("ref_fn.cout", {31'd0, cout}, {31'd0, ref_r.cout});
        chk_out("v_0011_0101_cin", 4'b1001, 1'b0, 1'b1, 1'b1);

        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_reset_mid", 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("async_reset_held", 4'b0000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        drive(4'b0100, 4'b0101, 1'b0, 1'b1);
        tick();
        chk_out("after_reset_vec", 4'b1001, 1'b0, 1'b1, 1'b1);

`ifdef FBFA_SUB_EN
        sub = 1'b1;
        drive(4'b0101, 4'b0011, 1'b0, 1'b1);
        tick();
        chk_out("sub_0101_0011", 4'b0010, 1'b1, 1'b0, 1'b1);
        sub = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
